mips_mem_loader: RTL

//  Boot-time loader for the single-cycle MIPS core: clears data memory and the register file,

---
 rtl/mips_mem_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mips_mem_loader.sv
// Boot-time loader for the single-cycle MIPS core.
// A session clears data memory and the register file, then streams bytes
// from an external valid/ready source into data memory at ascending byte
// addresses. The CPU is held in reset until one session has completed.
module mips_mem_loader #(
  parameter int DMEM_BYTES = 32,
  parameter int NREGS      = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [ADDR_W:0]   i_Len,
  input  logic              i_Byte_valid,
  input  logic [7:0]        i_Byte,
  output logic              o_Byte_ready,
  output logic              o_Dmem_we,
  output logic [ADDR_W-1:0] o_Dmem_addr,
  output logic [7:0]        o_Dmem_wdata,
  output logic              o_Reg_we,
  output logic [ADDR_W-1:0] o_Reg_addr,
  output logic [31:0]       o_Reg_wdata,
  output logic              o_Cpu_rst_n,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [ADDR_W:0]   o_Byte_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Longest session the memory can hold; longer requests are clamped here.
  localparam logic [ADDR_W:0]   LP_MAX_LEN  = (ADDR_W+1)'(DMEM_BYTES);
  // Index written on the final clear cycle.
  localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(NREGS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     r_len;
  logic                r_run;

  state_t              w_state_next;
  logic [ADDR_W-1:0]   w_idx_next;
  logic [ADDR_W:0]     w_count_next;
  logic [ADDR_W:0]     w_len_next;
  logic                w_run_next;
  logic [ADDR_W:0]     w_len_clamped;
  logic [ADDR_W:0]     w_count_inc;
  logic                w_room;
  logic                w_accept;

  // Session length as latched on start: min(i_Len, DMEM_BYTES).
  assign w_len_clamped = (i_Len > LP_MAX_LEN) ? LP_MAX_LEN : i_Len;
  assign w_count_inc   = r_count + (ADDR_W+1)'(1);
  // Count never passes len, so the byte after the last one is never taken
  // and the write address cannot wrap.
  assign w_room        = (r_count != r_len);
  assign w_accept      = (r_state == S_LOAD) && w_room && i_Byte_valid;

  assign o_Byte_count  = r_count;
  assign o_Reg_wdata   = '0;

  // Next-state, counter updates and all strobes, decoded from registered
  // state so the byte handshake completes in the same cycle it is offered.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_count_next = r_count;
    w_len_next   = r_len;
    w_run_next   = r_run;
    o_Byte_ready = 1'b0;
    o_Dmem_we    = 1'b0;
    o_Dmem_addr  = '0;
    o_Dmem_wdata = '0;
    o_Reg_we     = 1'b0;
    o_Reg_addr   = '0;
    o_Cpu_rst_n  = 1'b0;
    o_Busy       = (r_state != S_IDLE);
    o_Done       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // CPU is released only after a session has completed.
        o_Cpu_rst_n = r_run;
        if (i_Start) begin
          w_state_next = S_CLR;
          w_idx_next   = '0;
          w_count_next = '0;
          w_run_next   = 1'b0;
          w_len_next   = w_len_clamped;
        end
      end

      S_CLR: begin
        // Both memories are zeroed side by side, one entry per cycle.
        o_Dmem_we   = 1'b1;
        o_Dmem_addr = r_idx;
        o_Reg_we    = 1'b1;
        o_Reg_addr  = r_idx;
        w_idx_next  = r_idx + ADDR_W'(1);
        if (r_idx == LP_LAST_IDX) begin
          w_state_next = (r_len != '0) ? S_LOAD : S_DONE;
        end
      end

      S_LOAD: begin
        o_Byte_ready = w_room;
        if (w_accept) begin
          o_Dmem_we    = 1'b1;
          o_Dmem_addr  = r_count[ADDR_W-1:0];
          o_Dmem_wdata = i_Byte;
          w_count_next = w_count_inc;
          if (w_count_inc == r_len) begin
            w_state_next = S_DONE;
          end
        end
      end

      S_DONE: begin
        o_Done       = 1'b1;
        w_run_next   = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    if (!i_Rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_count <= w_count_next;
      r_len   <= w_len_next;
      r_run   <= w_run_next;
    end
  end

endmodule
